// File: rtl/io_pkg.sv
// Shared constants, io_output_bus field layout and key FSM encoding for the board I/O bridge.
package io_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int NUM_SW    = 10;
    localparam int NUM_HEX   = 6;
    localparam int HEX_WIDTH = 7;

    // Width of the core-facing buses.
    localparam int IN_BUS_W  = NUM_KEYS + NUM_SW;
    localparam int OUT_BUS_W = NUM_SW + NUM_HEX * HEX_WIDTH;

    // io_output_bus field offsets: LED in the low bits, then HEX0..HEX5 upward.
    localparam int LED_LSB  = 0;
    localparam int HEX0_LSB = 10;
    localparam int HEX1_LSB = 17;
    localparam int HEX2_LSB = 24;
    localparam int HEX3_LSB = 31;
    localparam int HEX4_LSB = 38;
    localparam int HEX5_LSB = 45;

    // Encoding chosen so bit 1 is the debounced "pressed" level, giving a
    // flop-direct output in PRESSED and WAIT_RELEASE.
    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'b00,
        KEY_WAIT_PRESS   = 2'b01,
        KEY_PRESSED      = 2'b11,
        KEY_WAIT_RELEASE = 2'b10
    } key_state_e;

    // Seven-segment pads are active-low: a lit segment in the core field drives 0.
    function automatic logic [HEX_WIDTH-1:0] seg_drive(input logic [HEX_WIDTH-1:0] field);
        return ~field;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: input synchronizer, four-state debounce FSM and stable-cycle counter.
module key_debouncer
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    // The transition fires on the edge where the count would reach DEBOUNCE_CYCLES-1,
    // so the output moves SYNC_STAGES + DEBOUNCE_CYCLES edges after a raw change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [SYNC_STAGES-1:0] r_sync;
    key_state_e             r_state;
    key_state_e             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_pressed;

    // Synchronizer chain; resets to the released (high) level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_n};
        end
    end

    assign w_pressed = ~r_sync[SYNC_STAGES-1];

    // Next-state and counter logic; the counter clears on every state change and
    // stops at CNT_LAST, so it can never wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            KEY_RELEASED: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (w_pressed) begin
                    w_state_nxt = KEY_WAIT_PRESS;
                end else begin
                    w_state_nxt = KEY_RELEASED;
                end
            end
            KEY_WAIT_PRESS: begin
                if (!w_pressed) begin
                    w_state_nxt = KEY_RELEASED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = KEY_PRESSED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            KEY_PRESSED: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (!w_pressed) begin
                    w_state_nxt = KEY_WAIT_RELEASE;
                end else begin
                    w_state_nxt = KEY_PRESSED;
                end
            end
            KEY_WAIT_RELEASE: begin
                if (w_pressed) begin
                    w_state_nxt = KEY_PRESSED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = KEY_RELEASED;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = KEY_RELEASED;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= KEY_RELEASED;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign key_db = r_state[1];

endmodule

// File: rtl/board_io_bridge.sv
// Board I/O bridge: debounced keys and synchronized switches to the core,
// registered seven-segment and LED drives from the core.
module board_io_bridge
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_KEYS-1:0]  key_n,
    input  logic [NUM_SW-1:0]    sw,
    output logic [IN_BUS_W-1:0]  io_input_bus,
    input  logic [OUT_BUS_W-1:0] io_output_bus,
    output logic [HEX_WIDTH-1:0] hex0_n,
    output logic [HEX_WIDTH-1:0] hex1_n,
    output logic [HEX_WIDTH-1:0] hex2_n,
    output logic [HEX_WIDTH-1:0] hex3_n,
    output logic [HEX_WIDTH-1:0] hex4_n,
    output logic [HEX_WIDTH-1:0] hex5_n,
    output logic [NUM_SW-1:0]    led
);

    logic [SYNC_STAGES-1:0][NUM_SW-1:0]  r_sw_sync;
    logic [NUM_HEX-1:0][HEX_WIDTH-1:0]   r_hex;
    logic [NUM_SW-1:0]                   r_led;
    logic [NUM_KEYS-1:0]                 w_key_db;

    // Switch synchronizer chain; switches are used as-is, no debouncing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_sync <= '0;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw};
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_key (
            .clock  (clock),
            .reset  (reset),
            .key_n  (key_n[g]),
            .key_db (w_key_db[g])
        );
    end

    assign io_input_bus = {w_key_db, r_sw_sync[SYNC_STAGES-1]};

    // Output registers: inverted hex fields and LED field, one cycle of latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hex <= '1;
            r_led <= '0;
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                r_hex[i] <= seg_drive(io_output_bus[HEX0_LSB + i*HEX_WIDTH +: HEX_WIDTH]);
            end
            r_led <= io_output_bus[LED_LSB +: NUM_SW];
        end
    end

    assign hex0_n = r_hex[0];
    assign hex1_n = r_hex[1];
    assign hex2_n = r_hex[2];
    assign hex3_n = r_hex[3];
    assign hex4_n = r_hex[4];
    assign hex5_n = r_hex[5];
    assign led    = r_led;

endmodule

// File: doc/board_io_bridge.md
BOARD_IO_BRIDGE -- requirements
Module: board_io_bridge

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles required to accept a key change (10 ms at 50 MHz); it SHALL be at least 2.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth for all board inputs; it SHALL be at least 2.
REQ-003 clock  in  1  system clock; one clock domain only.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 key_n  in  4  raw board push-buttons; active-low; asynchronous to clock.
REQ-006 sw  in  10  raw board slide switches; asynchronous to clock.
REQ-007 io_input_bus  out  14  feed to the core; bits [13:10] are the debounced keys, active-high pressed; bits [9:0] are the synchronized switches.
REQ-008 io_output_bus  in  52  from the core; field layout, from MSB: HEX5[51:45], HEX4[44:38], HEX3[37:31], HEX2[30:24], HEX1[23:17], HEX0[16:10], LED[9:0].
REQ-009 hex0_n..hex5_n  out  7 each  seven-segment pad drives; active-low, segment order {g..a}.
REQ-010 led  out  10  LED pad drives; active-high.

Function
REQ-011 Every key_n and sw bit SHALL pass through a SYNC_STAGES flop chain before any other use.
REQ-012 io_input_bus[9:0] SHALL equal sw delayed by exactly SYNC_STAGES clock edges, with no debouncing.
REQ-013 Each key SHALL have its own four-state FSM:
- RELEASED: goes to WAIT_PRESS when the synced key reads pressed.
- WAIT_PRESS: counts while the key stays pressed; goes to PRESSED when the count reaches DEBOUNCE_CYCLES-1; returns to RELEASED if the key reads released.
- PRESSED: goes to WAIT_RELEASE when the synced key reads released.
- WAIT_RELEASE: the mirror image of WAIT_PRESS.
REQ-014 The per-key counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide; it SHALL clear on every state transition, and it SHALL never wrap.
REQ-015 A debounced key bit SHALL be 1 exactly in the PRESSED and WAIT_RELEASE states.
REQ-016 The debounced output SHALL change after SYNC_STAGES + DEBOUNCE_CYCLES cycles of a constant raw level.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change, and the count SHALL restart from 0 on the next change.
REQ-018 The four keys SHALL be fully independent; simultaneous presses SHALL each be accepted on their own count.
REQ-019 hexN_n SHALL be the bitwise inverse of the HEXN field, registered, with 1-cycle latency.
REQ-020 led SHALL be the LED field, registered, with 1-cycle latency.
REQ-021 All outputs SHALL come directly from flops, with no combinational path from any input to any output.

Reset
REQ-022 Asserting reset (low) SHALL asynchronously take effect on all flops; release SHALL be sampled on a rising clock edge.
REQ-023 On reset, key synchronizer flops SHALL load 1 (released) and switch synchronizer flops SHALL load 0.
REQ-024 On reset, all FSMs SHALL enter RELEASED and all counters SHALL clear to 0.
REQ-025 Reset values of the outputs SHALL be: io_input_bus = 14'h0000; hex0_n..hex5_n = 7'h7F (all segments off); led = 10'h000.
REQ-026 A reset asserted mid-count or while PRESSED SHALL return the key to RELEASED with no output pulse after release.

Structure
REQ-027 Shared package io_pkg SHALL hold:
- NUM_KEYS=4, NUM_SW=10, NUM_HEX=6, HEX_WIDTH=7.
- The io_output_bus field offsets.
- The key FSM state enum.
REQ-028 Sub-module key_debouncer SHALL hold the synchronizer, FSM and counter for one key; it SHALL be instantiated NUM_KEYS times.
REQ-029 Switch synchronizers and output registers SHALL live in the top level.

Verification (bench uses DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
REQ-030 Reset: hold reset low with key_n=4'h0 and sw=10'h3FF -> io_input_bus=0, all hexN_n=7'h7F, led=0; after release, io_input_bus[9:0]=10'h3FF exactly 2 edges later.
REQ-031 Clean press: key_n[2] held at 0 -> io_input_bus[12] rises exactly 10 edges later; release held -> it falls 10 edges after release.
REQ-032 Bounce: key_n[0] low for 5 cycles, high for 1, then low steadily -> bit 10 stays 0 until 10 edges after the last falling edge.
REQ-033 Outputs: io_output_bus=52'hF_EDCB_A987_6543 -> one edge later led=10'h143 and hex0_n = ~io_output_bus[16:10]; all six fields checked.
REQ-034 Reset mid-debounce: key_n[3] low for 6 cycles, pulse reset low for 1 cycle, keep the key low -> bit 13 rises 10 edges after reset release, never earlier.
REQ-035 Concurrency: press keys 1 and 2 three cycles apart -> io_input_bus[11] and [12] rise three cycles apart.
